// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - buffered 8N1 UART transmitter: byte FIFO feeding a back-to-back serializer
module uart_tx_buffer #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] txdata,
  input  logic       tx_push,
  output logic       tx_full,
  output logic       tx_idle,
  output logic       tx_ovf,
  output logic       txd
);

  localparam int BIT   = 2 * CLK_PER_HALF_BIT;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(BIT);

  localparam logic [TW-1:0]         TIMER_LAST = TW'(BIT - 1);
  localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  state_t                state;
  logic [TW-1:0]         timer;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  push_ok;
  logic                  bit_done;
  logic                  pop;

  assign tx_full  = (count == COUNT_FULL);
  assign tx_idle  = (count == '0) && (state == S_IDLE);
  assign push_ok  = tx_push && !tx_full;
  assign bit_done = (timer == TIMER_LAST);
  // A pop only ever starts a new frame: from idle, or chained straight off a finishing stop bit.
  assign pop      = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && bit_done));

  always_ff @(posedge clk) begin
    if (rstn && push_ok) begin
      mem[wr_ptr] <= txdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      txd     <= 1'b1;
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_ovf  <= 1'b0;
    end else begin
      tx_ovf <= tx_push && tx_full;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + COUNT_ONE;
      else if (!push_ok && pop) count <= count - COUNT_ONE;

      case (state)
        S_IDLE: begin
          timer <= '0;
          txd   <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            timer   <= '0;
            txd     <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            timer <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        default: begin
          txd   <= 1'b1;
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - self-checking bench for uart_tx_buffer with a serial-line decoder and byte scoreboard
module tb_uart_tx_buffer;

  localparam int CPHB  = 2;
  localparam int DL2   = 2;
  localparam int BIT   = 2 * CPHB;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       tx_push = 1'b0;
  logic       tx_full;
  logic       tx_idle;
  logic       tx_ovf;
  logic       txd;

  uart_tx_buffer #(.CLK_PER_HALF_BIT(CPHB), .DEPTH_LOG2(DL2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .txdata  (txdata),
    .tx_push (tx_push),
    .tx_full (tx_full),
    .tx_idle (tx_idle),
    .tx_ovf  (tx_ovf),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         mon_cnt = -1;
  logic [7:0] mon_byte = 8'h00;
  int         idle_cyc = 0;
  int         c1 = 0;

  typedef struct {
    bit         push;
    logic [7:0] data;
    bit         acc;
    bit         full;
    bit         ovf;
    bit         idle;
  } vec_t;
  vec_t fv[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_push = 1'b1;
    txdata  = b;
    sb.push_back(b);
    step();
    tx_push = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (tx_idle !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("drain_in_time", (n < budget), 1);
    idle_cyc = cyc;
    check("scoreboard_empty", sb.size(), 0);
  endtask

  function automatic logic exp_line(input logic [7:0] d, input int i);
    int b = i / BIT;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Line decoder: samples each bit mid-period, reports bytes to the scoreboard.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_cnt = -1;
    end else if (mon_cnt < 0) begin
      if (txd === 1'b0) begin
        mon_cnt  = 0;
        mon_byte = 8'h00;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == BIT / 2) begin
        check("start_bit", txd, 0);
      end else if (mon_cnt < 9 * BIT && (mon_cnt % BIT) == BIT / 2) begin
        mon_byte = {txd, mon_byte[7:1]};
      end else if (mon_cnt == 9 * BIT + BIT / 2) begin
        check("stop_bit", txd, 1);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h expected no frame", mon_byte);
        end else begin
          check("frame_byte", mon_byte, sb.pop_front());
        end
      end
      if (mon_cnt == 10 * BIT - 1) mon_cnt = -1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fv[0] = '{1, 8'h01, 1, 0, 0, 0};
    fv[1] = '{1, 8'h02, 1, 0, 0, 0};
    fv[2] = '{1, 8'h03, 1, 0, 0, 0};
    fv[3] = '{1, 8'h04, 1, 0, 0, 0};
    fv[4] = '{1, 8'h05, 1, 1, 0, 0};
    fv[5] = '{1, 8'h06, 0, 1, 1, 0};
    fv[6] = '{0, 8'h00, 0, 1, 0, 0};

    // Reset with a push held: it must be ignored.
    rstn    = 1'b0;
    tx_push = 1'b1;
    txdata  = 8'hEE;
    repeat (3) step();
    tx_push = 1'b0;
    rstn    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_txd", txd, 1);
      check("idle_tx_idle", tx_idle, 1);
      check("idle_tx_full", tx_full, 0);
      check("idle_tx_ovf", tx_ovf, 0);
    end

    // Single byte with exact waveform.
    starts.delete();
    push_byte(8'hA5);
    check("a5_e0_txd", txd, 1);
    check("a5_e0_idle", tx_idle, 0);
    step();
    for (int i = 0; i < 10 * BIT; i++) begin
      check($sformatf("a5_line_%0d", i), txd, exp_line(8'hA5, i));
      if (i == 10 * BIT - 1) check("a5_idle_before_end", tx_idle, 0);
      step();
    end
    check("a5_idle_after_end", tx_idle, 1);
    wait_drain(100);
    check("a5_frames", starts.size(), 1);

    // Back-to-back frames.
    starts.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_drain(400);
    check("b2b_frames", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("b2b_gap_1", starts[1] - starts[0], 10 * BIT);
      check("b2b_gap_2", starts[2] - starts[1], 10 * BIT);
      check("b2b_total", idle_cyc - starts[0], 30 * BIT);
    end

    // Fill to full and overflow.
    starts.delete();
    for (int i = 0; i < 7; i++) begin
      tx_push = fv[i].push;
      txdata  = fv[i].data;
      if (fv[i].acc) sb.push_back(fv[i].data);
      step();
      check($sformatf("fill_%0d_full", i), tx_full, fv[i].full);
      check($sformatf("fill_%0d_ovf", i), tx_ovf, fv[i].ovf);
      check($sformatf("fill_%0d_idle", i), tx_idle, fv[i].idle);
    end
    tx_push = 1'b0;
    wait_drain(600);
    check("fill_frames", starts.size(), 5);
    if (starts.size() >= 1) check("fill_total", idle_cyc - starts[0], 50 * BIT);

    // Push coinciding with the pop of the only buffered byte.
    starts.delete();
    push_byte(8'h5A);
    check("pp_count_e0", dut.count, 1);
    push_byte(8'hC3);
    check("pp_count_e1", dut.count, 1);
    check("pp_txd_e1", txd, 0);
    check("pp_full_e1", tx_full, 0);
    wait_drain(300);
    check("pp_frames", starts.size(), 2);

    // Reset during data bit 3 with two bytes buffered.
    starts.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    c1 = cyc;
    push_byte(8'h33);
    while (cyc < c1 + 4 * BIT + 1) step();
    check("mid_bit3", txd, exp_line(8'h11, 4 * BIT + 1));
    rstn = 1'b0;
    sb.delete();
    step();
    rstn = 1'b1;
    check("rst_txd", txd, 1);
    check("rst_idle", tx_idle, 1);
    check("rst_full", tx_full, 0);
    check("rst_ovf", tx_ovf, 0);
    for (int i = 0; i < 60; i++) begin
      step();
      check("post_rst_txd", txd, 1);
      check("post_rst_idle", tx_idle, 1);
    end
    check("rst_frames", starts.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
